// File: rtl/data_ram_pl_if.sv
// data_ram_pl_if: request and read-response channels of the pipelined data RAM.
// The master side is the MEM stage; the slave side is the RAM.
interface data_ram_pl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W/8-1:0]   sel_i;
    logic [DATA_W-1:0]     wdata_i;
    logic                  ready_o;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_W-1:0]     rdata_o;
    logic                  rerr_o;
    logic                  werr_o;

    modport master (
        output req_i, we_i, addr_i, sel_i, wdata_i, rready_i,
        input  ready_o, rvalid_o, rdata_o, rerr_o, werr_o
    );

    modport slave (
        input  req_i, we_i, addr_i, sel_i, wdata_i, rready_i,
        output ready_o, rvalid_o, rdata_o, rerr_o, werr_o
    );
endinterface

// File: rtl/data_ram_pl.sv
// data_ram_pl: pipelined byte-lane data RAM, RD_LAT-stage read pipe with backpressure.
// Optional macro DATA_RAM_CLR_EN: zero the whole array after every reset.
module data_ram_pl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input logic         clk,
    input logic         rst,
    data_ram_pl_if.slave bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LB     = $clog2(LANES);
    localparam int IDX_HI = DEPTH_LOG2 + LB;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  adv;
    logic                  run;
    logic                  acc;
    logic                  rd_acc;
    logic                  werr;

    logic [RD_LAT-1:0]     st_v;
    logic [RD_LAT-1:0]     st_e;
    logic [DATA_W-1:0]     st_d [RD_LAT];

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_W-1:0]     wr_data;
    logic [LANES-1:0]      wr_sel;

    assign idx      = bus.addr_i[IDX_HI-1:LB];
    assign in_range = (bus.addr_i >> IDX_HI) == '0;
    assign adv      = !(st_v[RD_LAT-1] && !bus.rready_i);
    assign acc      = bus.req_i && bus.ready_o;
    assign rd_acc   = acc && !bus.we_i;

`ifdef DATA_RAM_CLR_EN
    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DEPTH_LOG2-1:0] clr_ptr;
    logic [DEPTH_LOG2-1:0] clr_ptr_nxt;

    // Clear FSM state and pointer; reset restarts the clear from word 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Walk clr_ptr over every word, then open the request port
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        run         = 1'b0;
        case (state)
            INIT: begin
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: run = 1'b1;
        endcase
    end
`else
    assign run = 1'b1;
`endif

    assign bus.ready_o = adv && run;

    // Array write port: clear sweep has priority, else in-range accepted writes
    always_comb begin
        wr_en   = acc && bus.we_i && in_range;
        wr_idx  = idx;
        wr_data = bus.wdata_i;
        wr_sel  = bus.sel_i;
`ifdef DATA_RAM_CLR_EN
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = clr_ptr;
            wr_data = '0;
            wr_sel  = '1;
        end
`endif
    end

    // Byte-lane array update; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int n = 0; n < LANES; n++) begin
                if (wr_sel[n]) begin
                    mem[wr_idx][8*n +: 8] <= wr_data[8*n +: 8];
                end
            end
        end
    end

    // Read pipe: stage 0 samples the array, later stages shift; all hold on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v <= '0;
            st_e <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                st_d[k] <= '0;
            end
        end else if (adv) begin
            st_v[0] <= rd_acc;
            st_e[0] <= rd_acc && !in_range;
            st_d[0] <= (rd_acc && in_range) ? mem[idx] : '0;
            for (int k = 1; k < RD_LAT; k++) begin
                st_v[k] <= st_v[k-1];
                st_e[k] <= st_e[k-1];
                st_d[k] <= st_d[k-1];
            end
        end
    end

    // Sticky flag for dropped out-of-range writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            werr <= 1'b0;
        end else if (acc && bus.we_i && !in_range) begin
            werr <= 1'b1;
        end
    end

    assign bus.rvalid_o = st_v[RD_LAT-1];
    assign bus.rerr_o   = st_e[RD_LAT-1];
    assign bus.rdata_o  = st_d[RD_LAT-1];
    assign bus.werr_o   = werr;
endmodule

// File: tb/tb_data_ram_pl.sv
// tb_data_ram_pl: directed vector table plus hand sequences for stall and reset.
// Build with DATA_RAM_CLR_EN to exercise the clear sweep with DEPTH_LOG2=4.
module tb_data_ram_pl;
`ifdef DATA_RAM_CLR_EN
    localparam int DL = 4;
`else
    localparam int DL = 10;
`endif
    localparam int LAT   = 2;
    localparam int DEPTH = 2 ** DL;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t tbl[$];
    logic [31:0] got[$];
    logic [31:0] last_a;
    logic [31:0] rst_exp;
    int   cnt;
    bit   seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_ram_pl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    data_ram_pl #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH_LOG2(DL),
        .RD_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
        int n;
        n = 0;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.sel_i   = sel;
        bus.wdata_i = wd;
        #1;
        while (!bus.ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.ready_o) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr,
                      input logic [31:0] exp, input logic err);
        int lat;
        send(1'b0, addr, 4'hF, 32'h0);
        lat = 1;
        while (!bus.rvalid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, lat, LAT);
        check({name, "_data"}, bus.rdata_o, exp);
        check({name, "_err"}, {31'd0, bus.rerr_o}, {31'd0, err});
        @(negedge clk);
    endtask

    task automatic count_clear(output int c);
        c = 0;
        #1;
        while (!bus.ready_o && c < 100) begin
            c++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.sel_i   = '0;
        bus.wdata_i = '0;
        bus.rready_i = 1'b1;
        last_a      = DEPTH * 4 - 4;

        repeat (2) @(negedge clk);
        check("rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_rerr", {31'd0, bus.rerr_o}, 32'd0);
        check("rst_werr", {31'd0, bus.werr_o}, 32'd0);
        rst = 1'b0;

`ifdef DATA_RAM_CLR_EN
        count_clear(cnt);
        check("clr_len", cnt, DEPTH);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("clr_rst_ready", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_clear(cnt);
        check("clr_restart_len", cnt, DEPTH);
        @(negedge clk);
        for (int w = 0; w < DEPTH; w++) begin
            rd($sformatf("clr_w%0d", w), w * 4, 32'h0, 1'b0);
        end
`else
        #1;
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        @(negedge clk);
`endif

        tbl.push_back('{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h10, 4'h4, 32'h00AA0000, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAABEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h10, 4'h0, 32'h12345678, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h13, 4'hF, 32'h0, 32'hDEAABEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h0, 4'hF, 32'h1, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 32'h4, 4'hF, 32'h2, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 32'h8, 4'hF, 32'h3, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 32'hC, 4'hF, 32'h4, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h0, 4'hF, 32'h0, 32'h1, 1'b0});
        tbl.push_back('{1'b1, last_a, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0});
        tbl.push_back('{1'b1, last_a, 4'h3, 32'h00001234, 32'h0, 1'b0});
        tbl.push_back('{1'b0, last_a, 4'hF, 32'h0, 32'hCAFE1234, 1'b0});
        tbl.push_back('{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, 32'h0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 11) begin
                check("werr_before_oor_wr", {31'd0, bus.werr_o}, 32'd0);
            end
            if (tbl[i].we) begin
                send(1'b1, tbl[i].addr, tbl[i].sel, tbl[i].wd);
            end else begin
                rd($sformatf("v%0d", i), tbl[i].addr, tbl[i].exp, tbl[i].err);
            end
        end
        check("werr_sticky", {31'd0, bus.werr_o}, 32'd1);

        // Four back-to-back reads with a three-cycle response stall
        bus.rready_i = 1'b1;
        fork
            begin
                int n;
                for (int i = 0; i < 4; i++) begin
                    n = 0;
                    bus.req_i  = 1'b1;
                    bus.we_i   = 1'b0;
                    bus.addr_i = i * 4;
                    #1;
                    while (!bus.ready_o && n < 50) begin
                        @(negedge clk);
                        #1;
                        n++;
                    end
                    @(negedge clk);
                end
                bus.req_i = 1'b0;
            end
            begin
                logic [31:0] held;
                bit stalled;
                int cyc;
                stalled = 1'b0;
                cyc = 0;
                while (got.size() < 4 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.rvalid_o) begin
                        if (!stalled) begin
                            stalled = 1'b1;
                            held = bus.rdata_o;
                            bus.rready_i = 1'b0;
                            for (int s = 0; s < 3; s++) begin
                                #1;
                                check("bp_ready_low", {31'd0, bus.ready_o}, 32'd0);
                                @(negedge clk);
                                check("bp_rvalid_hold", {31'd0, bus.rvalid_o}, 32'd1);
                                check("bp_rdata_hold", bus.rdata_o, held);
                            end
                            bus.rready_i = 1'b1;
                        end
                        got.push_back(bus.rdata_o);
                    end
                end
            end
        join
        @(negedge clk);
        check("bp_no_dup", {31'd0, bus.rvalid_o}, 32'd0);
        check("bp_count", got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                check($sformatf("bp_data%0d", i), got[i], i + 1);
            end
        end

        // Reset one cycle after a read accept drops the response
        send(1'b0, 32'h10, 4'hF, 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rvalid_o) seen = 1'b1;
        end
        check("mid_rst_no_resp", {31'd0, seen}, 32'd0);
        check("mid_rst_werr", {31'd0, bus.werr_o}, 32'd0);
`ifdef DATA_RAM_CLR_EN
        rst_exp = 32'h0;
`else
        rst_exp = 32'hDEAABEEF;
`endif
        rd("post_rst", 32'h10, rst_exp, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
